// File: rtl/zero_skip_sequencer.sv
// ============================================================================
// Module   : zero_skip_sequencer
// Purpose  : Read-side sequencer for the PE ifmap zero-flag buffer; scans each
//            window, gates MAC enables on zero taps, then slides the buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zero_skip_sequencer #(
    parameter int MEM_DEPTH  = 12,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] window_len,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  num_windows,
    input  logic                  window_ready,
    input  logic                  zero_flag,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  shift,
    output logic                  mac_en,
    output logic [ADDR_WIDTH-1:0] mac_addr,
    output logic                  mac_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  skip_count
);

    // One extra bit so a length equal to MEM_DEPTH is always representable.
    localparam int                  c_LEN_W = ADDR_WIDTH + 1;
    localparam logic [c_LEN_W-1:0]  c_DEPTH = c_LEN_W'(MEM_DEPTH);
    localparam logic [c_LEN_W-1:0]  c_ONE   = c_LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SCAN  = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_LEN_W-1:0]    r_len, w_len_nxt;
    logic [c_LEN_W-1:0]    r_stride, w_stride_nxt;
    logic [CNT_WIDTH-1:0]  r_num, w_num_nxt;
    logic [CNT_WIDTH-1:0]  r_win, w_win_nxt;
    logic [c_LEN_W-1:0]    r_sh, w_sh_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_shift_nxt;
    logic                  w_mac_en_nxt;
    logic [ADDR_WIDTH-1:0] w_mac_addr_nxt;
    logic                  w_mac_last_nxt;
    logic                  w_done_nxt;
    logic [CNT_WIDTH-1:0]  w_skip_nxt;
    logic [c_LEN_W-1:0]    w_len_in;
    logic [c_LEN_W-1:0]    w_stride_in;
    logic [CNT_WIDTH-1:0]  w_win_inc;
    logic                  w_tap_last;
    logic                  w_sh_last;

    // Out-of-range lengths (including zero) fall back to a full-depth window.
    assign w_len_in    = ({1'b0, window_len} == '0 || {1'b0, window_len} > c_DEPTH)
                         ? c_DEPTH : {1'b0, window_len};
    assign w_stride_in = ({1'b0, stride} == '0 || {1'b0, stride} > c_DEPTH)
                         ? c_DEPTH : {1'b0, stride};
    assign w_win_inc   = r_win + CNT_WIDTH'(1);
    assign w_tap_last  = ({1'b0, r_addr} == r_len - c_ONE);
    assign w_sh_last   = (r_sh == r_stride - c_ONE);

    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_stride_nxt   = r_stride;
        w_num_nxt      = r_num;
        w_win_nxt      = r_win;
        w_sh_nxt       = r_sh;
        w_addr_nxt     = r_addr;
        w_mac_en_nxt   = 1'b0;
        w_mac_addr_nxt = '0;
        w_mac_last_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_skip_nxt     = skip_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt    = w_len_in;
                    w_stride_nxt = w_stride_in;
                    w_num_nxt    = (num_windows == '0) ? CNT_WIDTH'(1) : num_windows;
                    w_win_nxt    = '0;
                    w_skip_nxt   = '0;
                    w_addr_nxt   = '0;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                w_addr_nxt = '0;
                if (window_ready) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_mac_en_nxt   = ~zero_flag;
                w_mac_addr_nxt = r_addr;
                w_mac_last_nxt = w_tap_last;
                if (zero_flag && (skip_count != '1)) begin
                    w_skip_nxt = skip_count + CNT_WIDTH'(1);
                end
                if (w_tap_last) begin
                    w_addr_nxt  = '0;
                    w_win_nxt   = w_win_inc;
                    w_sh_nxt    = '0;
                    w_state_nxt = (w_win_inc == r_num) ? S_DRAIN : S_SHIFT;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            S_SHIFT, S_DRAIN: begin
                w_sh_nxt = r_sh + c_ONE;
                if (w_sh_last) begin
                    if (r_state == S_DRAIN) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Shift is high for exactly the cycles spent in SHIFT/DRAIN.
        w_shift_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_len      <= c_ONE;
            r_stride   <= c_ONE;
            r_num      <= CNT_WIDTH'(1);
            r_win      <= '0;
            r_sh       <= '0;
            r_addr     <= '0;
            shift      <= 1'b0;
            mac_en     <= 1'b0;
            mac_addr   <= '0;
            mac_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            skip_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_stride   <= w_stride_nxt;
            r_num      <= w_num_nxt;
            r_win      <= w_win_nxt;
            r_sh       <= w_sh_nxt;
            r_addr     <= w_addr_nxt;
            shift      <= w_shift_nxt;
            mac_en     <= w_mac_en_nxt;
            mac_addr   <= w_mac_addr_nxt;
            mac_last   <= w_mac_last_nxt;
            busy       <= (w_state_nxt != S_IDLE);
            done       <= w_done_nxt;
            skip_count <= w_skip_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/zero_skip_sequencer.md
Name: zero_skip_sequencer

Overview:
Read-side controller for the PE ifmap zero-flag buffer.
- Sweeps read addresses across the current ifmap sliding window and samples each zero flag.
- Issues a gated MAC enable for each tap: the MAC fires only when the ifmap entry is non-zero. Zero entries are data-gated; no cycles are saved.
- After each window it issues stride-many shift pulses to slide the buffer. It repeats until the programmed number of windows is processed.

Parameters:
MEM_DEPTH, 12, depth of the zero-flag / ifmap scratchpad
ADDR_WIDTH, $clog2(MEM_DEPTH), scratchpad address width
CNT_WIDTH, 8, width of window counter and skip counter

Ports:
clk  input  1  clock; all sequencer state on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches configuration, begins run (ignored when busy)
window_len  input  ADDR_WIDTH  taps per window (filter width); legal 1..MEM_DEPTH
stride  input  ADDR_WIDTH  shift pulses between windows; legal 1..MEM_DEPTH
num_windows  input  CNT_WIDTH  windows per run; 0 treated as 1
window_ready  input  1  upstream: buffer holds at least window_len valid entries
zero_flag  input  1  flag read combinationally at r_addr
r_addr  output  ADDR_WIDTH  zero-flag read address
shift  output  1  one-cycle shift request to the buffer (registered)
mac_en  output  1  MAC enable for the tap at mac_addr
mac_addr  output  ADDR_WIDTH  ifmap/filter tap index for the MAC
mac_last  output  1  marks final tap of a window (asserted with the last mac_addr, whether gated or not)
busy  output  1  high from cycle after start until run complete
done  output  1  one-cycle pulse when the final window's shifts finish
skip_count  output  CNT_WIDTH  zero taps skipped in the current run (saturating)

Behaviour:
- Reset (reset=0, async): state IDLE; r_addr=0; shift=0; mac_en=0; mac_addr=0; mac_last=0; busy=0; done=0; skip_count=0. Reset mid-run aborts immediately; no further shift or mac_en pulses.
- Configuration registers latch on start in IDLE. Changes to inputs during a run are ignored.
- States:
  - IDLE: on start, go to WAIT; clear skip_count and the window counter.
  - WAIT: hold r_addr=0. When window_ready=1, go to SCAN.
  - SCAN: r_addr steps 0..window_len-1, one per cycle. In each SCAN cycle, with r_addr=k, sample zero_flag:
    - next posedge: mac_addr<=k; mac_en<=~zero_flag; mac_last<=(k==window_len-1).
    - if zero_flag=1, skip_count increments, saturating at all-ones.
    - after k=window_len-1: r_addr<=0, window counter +1.
    - if windows done == num_windows, go to DRAIN; else go to SHIFT.
  - SHIFT: assert registered shift for exactly stride consecutive cycles, then go to WAIT. No scanning while shift is high, because the buffer content moves under r_addr.
  - DRAIN: issue stride shift pulses as in SHIFT (the buffer leaves consumed entries), pulse done, go to IDLE.
- Latency: first mac_en appears 1 cycle after SCAN entry. Tap rate is 1 per cycle. Per-window cost is window_len + stride cycles plus WAIT time.
- mac_en, mac_addr and mac_last are one-cycle pulses. They return to 0 when not in the cycle following a SCAN cycle.
- busy is high while state≠IDLE. done rises in the same cycle busy falls.
- Boundary cases:
  - window_len=1: every SCAN is a single cycle with mac_last=1.
  - stride=MEM_DEPTH: full flush.
  - window_len/stride out of range: clamp to MEM_DEPTH.
  - window_ready dropping during SCAN is ignored; it is sampled only in WAIT.
  - start while busy is ignored.

Test Plan:
- Dense window:
  - stimulus: window_len=3, stride=1, num_windows=1, window_ready=1, all zero_flag=0.
  - required: r_addr 0,1,2; mac_en=1 for 3 cycles with mac_addr 0,1,2; mac_last on addr 2; 1 shift pulse; done; skip_count=0.
- Sparse window:
  - stimulus: flags at addr {0,1,2,3}=1,0,1,0; window_len=4.
  - required: mac_en pattern 0,1,0,1; mac_last with addr 3 (mac_en=0 is not required there since addr 3 has flag 0, so mac_en=1); skip_count=2.
- Multi-window:
  - stimulus: num_windows=3, stride=2, window_len=3.
  - required: 3 SCAN bursts; 2 shift pulses after each (6 total); done once after the 6th shift; busy for the full span.
- Backpressure:
  - stimulus: window_ready=0 for 5 cycles after start.
  - required: r_addr held 0, no mac_en, no shift; scan starts 1 cycle after window_ready=1.
- Abort:
  - stimulus: assert reset=0 mid-SCAN of window 2.
  - required: all outputs 0 immediately (async); a fresh start then runs from window 1.
- Saturation / ignored start:
  - stimulus: CNT_WIDTH=4, 20 zero taps.
  - required: skip_count holds 15.
  - stimulus: start pulsed while busy.
  - required: no effect.
